// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix skew feeder slice.
//   - DEFAULT_DATA_WIDTH / DEFAULT_N : default element width and matrix edge
//   - feeder_state_e                 : feeder FSM state encoding
//   - idx_width()                    : bits needed to index 0..n-1 (min 1)
package matrix_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_N          = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_buffer.sv
// NxN element store for the skew feeder.
// Writes one full column per cycle; every row lane can read its own column
// independently, which is what lets the feeder present a diagonal wavefront.
// Ports:
//   clk, sync_reset : clock, synchronous active-high reset (clears storage)
//   wr_en_i         : store wr_data_i as column wr_col_i
//   wr_col_i        : column index k
//   wr_data_i       : lane i holds A[i][k]
//   rd_en_i[i]      : lane i read enable; disabled lanes return 0
//   rd_col_i        : lane i column index at [i*IW +: IW]
//   rd_data_o       : lane i returns A[i][rd_col_i(i)] or 0
module skew_buffer
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N,
  localparam int IW        = idx_width(N)
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    wr_en_i,
  input  logic [IW-1:0]           wr_col_i,
  input  logic [N*DATA_WIDTH-1:0] wr_data_i,
  input  logic [N-1:0]            rd_en_i,
  input  logic [N*IW-1:0]         rd_col_i,
  output logic [N*DATA_WIDTH-1:0] rd_data_o
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    // Row gi of the matrix, column j at [j*DATA_WIDTH +: DATA_WIDTH].
    logic [N*DATA_WIDTH-1:0] row_q;
    logic [DATA_WIDTH-1:0]   rd_lane;

    always_ff @(posedge clk) begin
      if (sync_reset) begin
        row_q <= '0;
      end else if (wr_en_i) begin
        for (int j = 0; j < N; j++) begin
          if (wr_col_i == IW'(j)) begin
            row_q[j*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end

    always_comb begin
      rd_lane = '0;
      for (int j = 0; j < N; j++) begin
        if (rd_en_i[gi] && (rd_col_i[gi*IW +: IW] == IW'(j))) begin
          rd_lane = row_q[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_lane;
  end

endmodule

// File: rtl/matrix_skew_feeder.sv
// Loads an NxN matrix column by column, then streams it into N downstream
// shift registers as a skewed wavefront (lane i delayed by i cycles),
// followed by N zero cycles so the last element leaves an N-deep register.
// Ports:
//   clk, sync_reset : clock, synchronous active-high reset
//   start           : begin one load/stream operation (ignored while busy)
//   in_valid/ready  : column beat handshake, in_data lane i = A[i][k]
//   out_shift       : shift enable to the downstream registers
//   out_data        : lane i feeds downstream register i
//   out_clear       : one-cycle clear of the downstream registers
//   busy            : high outside IDLE
//   done            : one-cycle completion pulse
module matrix_skew_feeder
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N
) (
  input  logic                    clk,
  input  logic                    sync_reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic                    out_shift,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    out_clear,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(2*N);
  localparam int IW = idx_width(N);

  localparam logic [CW-1:0]        LOAD_LAST   = CW'(N-1);
  localparam logic [CW-1:0]        STREAM_LAST = CW'(2*N-2);
  localparam logic [CW-1:0]        FLUSH_LAST  = CW'(N-1);
  localparam logic signed [CW:0]   N_S         = (CW+1)'(N);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clear_q, clear_d;
  logic          beat_accept;
  logic          streaming;
  logic [N-1:0]    rd_en;
  logic [N*IW-1:0] rd_col;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clear_q <= clear_d;
    end
  end

  // The single counter is reused per state: beat index in LOAD, wavefront
  // time t in STREAM, zero-cycle index in FLUSH. It restarts at every
  // state change so it never needs to wrap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clear_d     = 1'b0;
    in_ready    = 1'b0;
    out_shift   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    beat_accept = 1'b0;
    streaming   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) begin
          state_d = ST_LOAD;
          clear_d = 1'b1;  // out_clear is high only for the first LOAD cycle
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          beat_accept = 1'b1;
          if (cnt_q == LOAD_LAST) begin
            state_d = ST_STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_STREAM: begin
        out_shift = 1'b1;
        streaming = 1'b1;
        if (cnt_q == STREAM_LAST) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        out_shift = 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign out_clear = clear_q;

  // Lane i reads column t-i. The difference is formed signed so lanes that
  // have not started yet (t<i) or have finished (t-i>=N) read as 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic signed [CW:0] diff;
    assign diff                  = $signed({1'b0, cnt_q}) - $signed((CW+1)'(gi));
    assign rd_en[gi]             = streaming && !diff[CW] && (diff < N_S);
    assign rd_col[gi*IW +: IW]   = diff[IW-1:0];
  end

  skew_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N)
  ) u_buffer (
    .clk        (clk),
    .sync_reset (sync_reset),
    .wr_en_i    (beat_accept),
    .wr_col_i   (cnt_q[IW-1:0]),
    .wr_data_i  (in_data),
    .rd_en_i    (rd_en),
    .rd_col_i   (rd_col),
    .rd_data_o  (out_data)
  );

endmodule

// File: tb/tb_matrix_skew_feeder.sv
// Self-checking bench for matrix_skew_feeder (N=4, DATA_WIDTH=8).
// A time-based reference model (cycles elapsed since the load completed)
// predicts every output each cycle; four behavioural downstream shift
// registers are driven by both the DUT and the model and compared.
module tb_matrix_skew_feeder;

  localparam int DW        = 8;
  localparam int N         = 4;
  localparam int NW        = N * DW;
  localparam int LAST_POST = 3*N - 1;  // cycle index of the DONE cycle

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_data;
  logic          out_shift;
  logic [NW-1:0] out_data;
  logic          out_clear;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  matrix_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_shift  (out_shift),
    .out_data   (out_data),
    .out_clear  (out_clear),
    .busy       (busy),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_busy  = 1'b0;
  int            m_beats = 0;
  int            m_post  = -1;   // -1 while loading, else cycles since load finished
  bit            m_first = 1'b0;
  logic [DW-1:0] mA  [N][N];
  logic [DW-1:0] mds [N][N];     // model downstream registers
  logic [DW-1:0] ds  [N][N];     // DUT-driven downstream registers

  typedef struct packed {
    logic          in_ready;
    logic          out_shift;
    logic          out_clear;
    logic          busy;
    logic          done;
    logic [NW-1:0] data;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (m_busy) begin
      e.busy = 1'b1;
      if (m_post < 0) begin
        e.in_ready  = 1'b1;
        e.out_clear = m_first;
      end else if (m_post == LAST_POST) begin
        e.done = 1'b1;
      end else begin
        e.out_shift = 1'b1;
        if (m_post <= 2*N-2) begin
          for (int i = 0; i < N; i++) begin
            if (m_post - i >= 0 && m_post - i < N) e.data[i*DW +: DW] = mA[i][m_post-i];
          end
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (sync_reset) begin
      m_busy = 1'b0; m_beats = 0; m_post = -1; m_first = 1'b0;
      for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mA[i][j] = '0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_beats = 0; m_post = -1; m_first = 1'b1;
      end
    end else begin
      m_first = 1'b0;
      if (m_post < 0) begin
        if (in_valid) begin
          for (int i = 0; i < N; i++) mA[i][m_beats] = in_data[i*DW +: DW];
          m_beats++;
          if (m_beats == N) m_post = 0;
        end
      end else if (m_post == LAST_POST) begin
        m_busy = 1'b0;
      end else begin
        m_post++;
      end
    end
  end

  // Compare on the falling edge, then advance both downstream register sets.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model_out();
      check("in_ready",  64'(in_ready),  64'(e.in_ready));
      check("out_shift", 64'(out_shift), 64'(e.out_shift));
      check("out_clear", 64'(out_clear), 64'(e.out_clear));
      check("busy",      64'(busy),      64'(e.busy));
      check("done",      64'(done),      64'(e.done));
      check("out_data",  64'(out_data),  64'(e.data));
      for (int i = 0; i < N; i++) check("ds_tail", 64'(ds[i][N-1]), 64'(mds[i][N-1]));
      if (e.done) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) check("ds_zero_at_done", 64'(ds[i][j]), 64'(0));
      end
      for (int i = 0; i < N; i++) begin
        if (out_clear) begin
          for (int j = 0; j < N; j++) ds[i][j] = '0;
        end else if (out_shift) begin
          for (int j = N-1; j > 0; j--) ds[i][j] = ds[i][j-1];
          ds[i][0] = out_data[i*DW +: DW];
        end
        if (e.out_clear) begin
          for (int j = 0; j < N; j++) mds[i][j] = '0;
        end else if (e.out_shift) begin
          for (int j = N-1; j > 0; j--) mds[i][j] = mds[i][j-1];
          mds[i][0] = e.data[i*DW +: DW];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] col_pattern(input int k);
    logic [NW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(16*i + k);
    return v;
  endfunction

  // One operation with A[i][k]=16*i+k; continuous or 1,0,1,0 in_valid.
  task automatic run_directed(input bit toggle, input string tag);
    int acc, shifts, clears, dones, beat_last_cyc, shift0_cyc;
    bit tog;
    logic [NW-1:0] seq [16];
    acc = 0; shifts = 0; clears = 0; dones = 0;
    beat_last_cyc = -1; shift0_cyc = -1; tog = 1'b1;
    for (int k = 0; k < 16; k++) seq[k] = '0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && busy; cyc++) begin
      if (out_clear) clears++;
      if (done) dones++;
      if (out_shift) begin
        if (shifts == 0) shift0_cyc = cyc;
        if (shifts < 16) seq[shifts] = out_data;
        shifts++;
      end
      in_data = col_pattern(acc < N ? acc : 0);
      if (in_ready) begin
        in_valid = toggle ? tog : 1'b1;
        tog = ~tog;
        if (in_valid) begin
          acc++;
          if (acc == N) beat_last_cyc = cyc;
        end
      end else begin
        in_valid = 1'b0;
      end
      cycle();
    end
    in_valid = 1'b0;
    check({tag, "_busy_low_after"}, 64'(busy), 64'(0));
    check({tag, "_clear_pulses"}, 64'(clears), 64'(1));
    check({tag, "_done_pulses"},  64'(dones),  64'(1));
    check({tag, "_shift_cycles"}, 64'(shifts), 64'(3*N-1));
    check({tag, "_beats"},        64'(acc),    64'(N));
    check({tag, "_t1"}, 64'(seq[1]), 64'(32'h00001001));
    check({tag, "_t3"}, 64'(seq[3]), 64'(32'h30211203));
    check({tag, "_t6"}, 64'(seq[6]), 64'(32'h33000000));
    for (int k = 2*N-1; k < 3*N-1; k++) check({tag, "_flush_zero"}, 64'(seq[k]), 64'(0));
    check({tag, "_stream_after_last_beat"}, 64'(shift0_cyc), 64'(beat_last_cyc + 1));
    $display("op %s: beats=%0d shifts=%0d t3=%h", tag, acc, shifts, seq[3]);
  endtask

  initial begin
    int dcyc, dones;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
      ds[i][j] = '0; mds[i][j] = '0; mA[i][j] = '0;
    end
    sync_reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_ready", 64'(in_ready),  64'(0));
    check("rst_shift", 64'(out_shift), 64'(0));
    check("rst_clear", 64'(out_clear), 64'(0));
    check("rst_done",  64'(done),      64'(0));
    check("rst_data",  64'(out_data),  64'(0));
    sync_reset = 1'b0;
    in_valid = 1'b1;  // ignored outside LOAD
    cycle();
    check("idle_valid_ignored", 64'(busy), 64'(0));
    in_valid = 1'b0;
    cycle();

    run_directed(1'b0, "basic");
    run_directed(1'b1, "toggle");

    // Abort with reset at STREAM t=2.
    start = 1'b1;
    cycle();
    start = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !(m_busy && m_post == 2); c++) begin
      in_data = $urandom;
      cycle();
    end
    check("abort_in_stream", 64'(out_shift), 64'(1));
    sync_reset = 1'b1;
    cycle();
    sync_reset = 1'b0;
    in_valid = 1'b0;
    check("abort_busy",  64'(busy),      64'(0));
    check("abort_shift", 64'(out_shift), 64'(0));
    check("abort_data",  64'(out_data),  64'(0));
    check("abort_ready", 64'(in_ready),  64'(0));
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) dones++;
      cycle();
    end
    check("abort_no_done", 64'(dones), 64'(0));
    $display("op abort: reset at stream t=2");
    run_directed(1'b0, "after_abort");

    // start held high: exactly one operation, next begins after one IDLE cycle.
    start = 1'b1;
    in_valid = 1'b1;
    cycle();
    dcyc = -1;
    for (int c = 0; c < 100; c++) begin
      if (done && dcyc < 0) dcyc = c;
      if (dcyc >= 0 && c == dcyc + 1) check("hold_idle_gap", 64'(busy), 64'(0));
      if (dcyc >= 0 && c == dcyc + 2) begin
        check("hold_restart", 64'(busy), 64'(1));
        check("hold_clear", 64'(out_clear), 64'(1));
        break;
      end
      in_data = $urandom;
      cycle();
    end
    check("hold_done_seen", 64'(dcyc >= 0), 64'(1));
    start = 1'b0;
    for (int c = 0; c < 100 && busy; c++) begin
      in_data = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    check("hold_second_end", 64'(busy), 64'(0));
    $display("op hold_start: two back-to-back operations");

    // start and reset together from IDLE.
    start = 1'b1;
    sync_reset = 1'b1;
    cycle();
    check("start_rst_busy",  64'(busy),      64'(0));
    check("start_rst_clear", 64'(out_clear), 64'(0));
    start = 1'b0;
    sync_reset = 1'b0;
    cycle();
    check("start_rst_idle", 64'(busy), 64'(0));
    $display("op start_with_reset: stayed idle");

    // Randomized operations with occasional aborts.
    for (int op = 0; op < 25; op++) begin
      int gap, abort_at;
      gap = $urandom_range(0, 3);
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : -1;
      repeat (gap) begin
        in_valid = 1'($urandom);
        in_data = $urandom;
        cycle();
      end
      start = 1'b1;
      in_valid = 1'($urandom);
      in_data = $urandom;
      cycle();
      for (int c = 0; c < 200 && busy; c++) begin
        start = ($urandom_range(0, 7) == 0);
        in_valid = ($urandom_range(0, 99) < 65);
        in_data = $urandom;
        sync_reset = (c == abort_at);
        cycle();
      end
      sync_reset = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      check("rand_op_end", 64'(busy), 64'(0));
      $display("op rand%0d: abort_at=%0d", op, abort_at);
    end

    repeat (3) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
